// File: rtl/imem_pixel_reader.sv
// IMEM read side: fetches R,G,B bytes per pixel and streams {R,G,B} pixels over valid/ready.
// Define IMEM_READER_BGR_ORDER_EN when IMEM holds bytes as B,G,R; pix_data stays {R,G,B}.
module imem_pixel_reader #(
  parameter int unsigned                IMEM_WIDTH     = 8,
  parameter int unsigned                ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]      IMEM_BASE_ADDR = '0,
  parameter int unsigned                MAX_PIXELS     = 40 * 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        pause,
  input  logic                        abort,
  input  logic [15:0]                 num_pixels,
  output logic                        mem_rd_en,
  output logic [ADDR_WIDTH-1:0]       mem_rd_addr,
  input  logic [IMEM_WIDTH-1:0]       mem_rd_data,
  output logic                        pix_valid,
  input  logic                        pix_ready,
  output logic [3*IMEM_WIDTH-1:0]     pix_data,
  output logic                        pix_last,
  output logic [2:0]                  state,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_WAIT  = 3'd1,
    ST_PROC  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_ABORT = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t                  state_q;
  logic [15:0]             n_q;
  logic [15:0]             idx_q;
  logic [1:0]              rd_cnt_q;
  logic                    cap_vld_q;
  logic [1:0]              cap_off_q;
  logic [IMEM_WIDTH-1:0]   byte0_q;
  logic [IMEM_WIDTH-1:0]   byte1_q;

  logic [15:0]             n_clamp;
  logic [15:0]             idx_nxt;
  logic [3*IMEM_WIDTH-1:0] pix_nxt;

  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [15:0] i);
    return IMEM_BASE_ADDR + ADDR_WIDTH'({i, 1'b0}) + ADDR_WIDTH'(i);
  endfunction

  always_comb begin
    n_clamp = num_pixels;
    if (32'(num_pixels) > MAX_PIXELS) n_clamp = 16'(MAX_PIXELS);
    idx_nxt = idx_q + 16'd1;
    // third byte is assembled straight from the memory bus in the cycle it arrives
`ifdef IMEM_READER_BGR_ORDER_EN
    pix_nxt = {mem_rd_data, byte1_q, byte0_q};
`else
    pix_nxt = {byte0_q, byte1_q, mem_rd_data};
`endif
  end

  assign state = state_q;
  assign busy  = (state_q == ST_PROC) || (state_q == ST_PAUSE);
  assign done  = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      n_q         <= '0;
      idx_q       <= '0;
      rd_cnt_q    <= '0;
      cap_vld_q   <= 1'b0;
      cap_off_q   <= '0;
      byte0_q     <= '0;
      byte1_q     <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_last    <= 1'b0;
    end else begin
      case (state_q)
        ST_RESET: state_q <= ST_WAIT;

        ST_WAIT: begin
          if (start) begin
            n_q       <= n_clamp;
            idx_q     <= '0;
            cap_vld_q <= 1'b0;
            if (n_clamp == 16'd0) begin
              state_q <= ST_DONE;
            end else begin
              state_q     <= ST_PROC;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= addr_of(16'd0);
              rd_cnt_q    <= '0;
            end
          end
        end

        ST_PROC: begin
          if (abort) begin
            state_q   <= ST_ABORT;
            mem_rd_en <= 1'b0;
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            cap_vld_q <= 1'b0;
          end else begin
            cap_vld_q <= mem_rd_en;
            cap_off_q <= rd_cnt_q;
            if (mem_rd_en) begin
              if (rd_cnt_q == 2'd2) begin
                mem_rd_en <= 1'b0;
                rd_cnt_q  <= '0;
              end else begin
                rd_cnt_q    <= rd_cnt_q + 2'd1;
                mem_rd_addr <= mem_rd_addr + 1'b1;
              end
            end
            if (cap_vld_q) begin
              case (cap_off_q)
                2'd0: byte0_q <= mem_rd_data;
                2'd1: byte1_q <= mem_rd_data;
                default: begin
                  pix_data  <= pix_nxt;
                  pix_valid <= 1'b1;
                  pix_last  <= (idx_q == n_q - 16'd1);
                end
              endcase
            end
            // the accept edge is the pixel boundary: pause is decided here, before the next fetch
            if (pix_valid && pix_ready) begin
              pix_valid <= 1'b0;
              pix_last  <= 1'b0;
              if (pix_last) begin
                state_q <= ST_DONE;
              end else begin
                idx_q <= idx_nxt;
                if (pause) begin
                  state_q <= ST_PAUSE;
                end else begin
                  mem_rd_en   <= 1'b1;
                  mem_rd_addr <= addr_of(idx_nxt);
                  rd_cnt_q    <= '0;
                end
              end
            end
          end
        end

        ST_PAUSE: begin
          if (abort) begin
            state_q <= ST_ABORT;
          end else if (!pause) begin
            state_q     <= ST_PROC;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= addr_of(idx_q);
            rd_cnt_q    <= '0;
          end
        end

        ST_ABORT: state_q <= ST_WAIT;

        ST_DONE: begin
          if (!start) state_q <= ST_WAIT;
        end

        default: state_q <= ST_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_pixel_reader.sv
// Bench for imem_pixel_reader: memory model, per-cycle scoreboard against pass-level rules,
// directed scenarios with literal expectations and randomized passes.
module tb_imem_pixel_reader;
  // reduced pixel capacity keeps the clamped full-capacity pass short
  localparam int unsigned MAXP = 1024;
  localparam int unsigned MEMB = 3 * MAXP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] num_pixels = '0;
  logic        mem_rd_en;
  logic [31:0] mem_rd_addr;
  logic [7:0]  mem_rd_data = '0;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic [23:0] pix_data;
  logic        pix_last;
  logic [2:0]  state;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  imem_pixel_reader #(
    .IMEM_WIDTH(8),
    .ADDR_WIDTH(32),
    .IMEM_BASE_ADDR(32'd0),
    .MAX_PIXELS(MAXP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .abort(abort),
    .num_pixels(num_pixels), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_last(pix_last), .state(state), .busy(busy), .done(done)
  );

  logic [7:0] mem [0:MEMB-1];

  always @(posedge clk)
    if (mem_rd_en) mem_rd_data <= (mem_rd_addr < MEMB) ? mem[mem_rd_addr[11:0]] : 8'h00;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_pix(input int i);
`ifdef IMEM_READER_BGR_ORDER_EN
    return {mem[3*i+2], mem[3*i+1], mem[3*i]};
`else
    return {mem[3*i], mem[3*i+1], mem[3*i+2]};
`endif
  endfunction

  // scoreboard state: reads issued and pixels accepted in the current pass
  int          exp_n = 0;
  int          rd_cnt = 0;
  int          acc_cnt = 0;
  longint      last_rd_addr = -1;
  logic [23:0] got[$];
  logic        p_valid = 0, p_ready = 0, p_last = 0, p_pause = 0, p_abort = 0;
  logic [23:0] p_data = '0;
  logic [2:0]  p_state = 3'd0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy_flag", busy, (state == 3'd2 || state == 3'd3));
      check("done_flag", done, (state == 3'd5));
      check("last_qual", (!pix_last || pix_valid), 1);
      if (state != 3'd2) begin
        check("idle_rd_en", mem_rd_en, 0);
        check("idle_valid", pix_valid, 0);
      end
      if (mem_rd_en) begin
        check("rd_addr", mem_rd_addr, rd_cnt);
        check("rd_range", (mem_rd_addr < MEMB), 1);
        check("rd_not_ahead", (rd_cnt < 3 * (acc_cnt + 1)), 1);
        last_rd_addr = mem_rd_addr;
        rd_cnt++;
      end
      if (p_valid && !p_ready && p_state == 3'd2 && state == 3'd2) begin
        check("stall_valid", pix_valid, 1);
        check("stall_data", pix_data, p_data);
        check("stall_last", pix_last, p_last);
      end
      if (pix_valid && pix_ready) begin
        check("pix_data", pix_data, exp_pix(acc_cnt));
        check("pix_last", pix_last, (acc_cnt == exp_n - 1));
        check("pix_reads_done", rd_cnt, 3 * (acc_cnt + 1));
        got.push_back(pix_data);
        acc_cnt++;
      end
      if (state == 3'd5 && p_state != 3'd5) check("done_count", acc_cnt, exp_n);
      if (state == 3'd3 && p_state == 3'd2) check("pause_boundary", rd_cnt, 3 * acc_cnt);
      if (p_state == 3'd3 && !p_pause && !p_abort) check("resume", state, 2);
      if ((p_state == 3'd2 || p_state == 3'd3) && p_abort) check("abort_next", state, 4);
      if (p_state == 3'd2 && p_valid && p_ready && p_last && !p_abort) check("last_to_done", state, 5);
      if (p_state == 3'd4) check("abort_len", state, 1);
      if (state == 3'd1) begin
        rd_cnt  = 0;
        acc_cnt = 0;
      end
      p_valid = pix_valid; p_ready = pix_ready; p_last = pix_last; p_data = pix_data;
      p_state = state; p_pause = pause; p_abort = abort;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    num_pixels = 16'(n);
    exp_n      = (n > int'(MAXP)) ? int'(MAXP) : n;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic finish_pass(input int budget, input bit rnd);
    int c = 0;
    while (!(state == 3'd5 || state == 3'd1) && c < budget) begin
      if (rnd) begin
        pix_ready = ($urandom_range(0, 9) < 7);
        if (pause) pause = ($urandom_range(0, 3) != 0);
        else       pause = ($urandom_range(0, 19) == 0);
        abort = busy && ($urandom_range(0, 149) == 0);
      end
      step();
      abort = 1'b0;
      c++;
    end
    check("pass_in_budget", (c < budget), 1);
    pause = 1'b0; abort = 1'b0; pix_ready = 1'b1;
    if (state == 3'd5) step();
  endtask

  initial begin
    int cyc;
    int stall;
    for (int i = 0; i < int'(MEMB); i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) mem[i] = 8'(10 * (i + 1));

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_addr", mem_rd_addr, 0);
    check("rst_valid", pix_valid, 0);
    check("rst_data", pix_data, 0);
    check("rst_last", pix_last, 0);
    check("rst_state", state, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("rel_state0", state, 0);
    step();
    check("rel_state1", state, 1);

    abort = 1'b1;
    step();
    check("abort_in_wait", state, 1);
    abort = 1'b0;

    // two pixels at full ready
    got.delete();
    do_start(2);
    cyc = 1;
    while (state != 3'd5 && cyc < 50) begin step(); cyc++; end
    check("n2_done_cycles", cyc, 11);
    check("n2_count", got.size(), 2);
`ifdef IMEM_READER_BGR_ORDER_EN
    check("n2_pix0", got[0], 24'h1E140A);
    check("n2_pix1", got[1], 24'h3C3228);
`else
    check("n2_pix0", got[0], 24'h0A141E);
    check("n2_pix1", got[1], 24'h28323C);
`endif
    check("n2_last_addr", last_rd_addr, 5);
    step();
    check("n2_back_wait", state, 1);

    // stall pixel 1 for four cycles
    got.delete();
    stall = 0;
    do_start(3);
    cyc = 0;
    while (state != 3'd5 && cyc < 100) begin
      if (acc_cnt == 1 && pix_valid && stall < 4) begin
        pix_ready = 1'b0;
        stall++;
        check("stall_no_rd", mem_rd_en, 0);
      end else pix_ready = 1'b1;
      step();
      cyc++;
    end
    pix_ready = 1'b1;
    check("stall_cycles", stall, 4);
    check("stall_count", got.size(), 3);
    step();

    // pause during the fetch of pixel 1
    got.delete();
    do_start(4);
    cyc = 0;
    while (!(mem_rd_en && mem_rd_addr == 32'd3) && cyc < 30) begin step(); cyc++; end
    pause = 1'b1;
    cyc = 0;
    while (state != 3'd3 && cyc < 30) begin step(); cyc++; end
    check("pause_state", state, 3);
    check("pause_delivered", got.size(), 2);
    for (int k = 0; k < 3; k++) begin
      step();
      check("pause_hold", state, 3);
      check("pause_no_rd", mem_rd_en, 0);
    end
    pause = 1'b0;
    step();
    check("resume_state", state, 2);
    check("resume_rd_en", mem_rd_en, 1);
    check("resume_addr", mem_rd_addr, 6);
    finish_pass(100, 1'b0);
    check("pause_total", got.size(), 4);

    // abort during the fetch of pixel 5
    do_start(10);
    cyc = 0;
    while (!(mem_rd_en && mem_rd_addr == 32'd15) && cyc < 60) begin step(); cyc++; end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_state", state, 4);
    check("abort_rd_en", mem_rd_en, 0);
    check("abort_valid", pix_valid, 0);
    step();
    check("abort_to_wait", state, 1);
    do_start(2);
    check("restart_rd_en", mem_rd_en, 1);
    check("restart_addr", mem_rd_addr, 0);
    finish_pass(100, 1'b0);

    // zero pixels
    do_start(0);
    check("n0_state", state, 5);
    check("n0_done", done, 1);
    step();
    check("n0_wait", state, 1);

    // clamp to capacity
    got.delete();
    do_start(65535);
    finish_pass(5 * MAXP + 50, 1'b0);
    check("clamp_count", got.size(), MAXP);
    check("clamp_last_addr", last_rd_addr, MEMB - 1);

    // randomized passes
    for (int p = 0; p < 40; p++) begin
      do_start($urandom_range(0, 12));
      finish_pass(2000, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
